// File: rtl/flex_downsample_stream.sv
// Streaming nearest-sample downscaler: Q8.8 stride, per-channel square frames.
module flex_downsample_stream #(
  parameter int DW   = 8,
  parameter int HMAX = 64,
  parameter int CMAX = 256,
  localparam int HW  = $clog2(HMAX + 1),
  localparam int CW  = $clog2(CMAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [HW-1:0] cfg_hin,
  input  logic [HW-1:0] cfg_hout,
  input  logic [CW-1:0] cfg_cin,
  input  logic [15:0]   cfg_stride,
  input  logic          cfg_round,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [CW-1:0] out_chan
);

  localparam int AW = HW + 9;
  localparam int SW = HW + 17;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nx;
  logic [HW-1:0] hin_q, hout_q;
  logic [CW-1:0] cin_q;
  logic [15:0]   stride_q;
  logic          rnd_q;
  logic [SW-1:0] span;
  logic          cfg_legal;

  logic [HW-1:0] row, col, row_cnt, col_cnt;
  logic [AW-1:0] row_acc, col_acc, off_q, off_new;
  logic [CW-1:0] chan;
  logic          row_hit, col_hit, accept, push, push_last;
  logic          col_end, row_end, chan_end, last_px, kill, begin_job;

  logic [DW-1:0] mem_d [2];
  logic          mem_l [2];
  logic [CW-1:0] mem_c [2];
  logic          wr_ptr, rd_ptr, pop;
  logic [1:0]    cnt;

  always_comb begin
    span      = SW'(cfg_hout - HW'(1)) * SW'(cfg_stride) + (cfg_round ? SW'(128) : '0);
    cfg_legal = (cfg_hin != '0) && (cfg_hout != '0) && (cfg_cin != '0) &&
                (cfg_hin <= HW'(HMAX)) && (cfg_cin <= CW'(CMAX)) &&
                (cfg_stride >= 16'd256) && ((span >> 8) < SW'(cfg_hin));
  end

  always_comb begin
    off_q     = rnd_q ? AW'(128) : '0;
    off_new   = cfg_round ? AW'(128) : '0;
    // Sample counters gate the hit so accumulators may overrun past the last sample.
    row_hit   = ({1'b0, row} == row_acc[AW-1:8]) && (row_cnt != hout_q);
    col_hit   = ({1'b0, col} == col_acc[AW-1:8]) && (col_cnt != hout_q);
    in_ready  = (state == RUN) && (cnt != 2'd2) && !abort;
    accept    = in_valid && in_ready;
    push      = accept && row_hit && col_hit;
    push_last = (row_cnt == hout_q - HW'(1)) && (col_cnt == hout_q - HW'(1));
    col_end   = (col == hin_q - HW'(1));
    row_end   = (row == hin_q - HW'(1));
    chan_end  = (chan == cin_q - CW'(1));
    last_px   = accept && col_end && row_end && chan_end;
    kill      = (state != IDLE) && abort;
    begin_job = (state == IDLE) && start;
    out_valid = (cnt != 2'd0);
    pop       = out_valid && out_ready;
    out_data  = out_valid ? mem_d[rd_ptr] : '0;
    out_last  = out_valid ? mem_l[rd_ptr] : 1'b0;
    out_chan  = out_valid ? mem_c[rd_ptr] : '0;
    busy      = (state != IDLE);
    done      = (state == DRAIN) && !abort && ((cnt == 2'd0) || ((cnt == 2'd1) && pop));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && cfg_legal) state_nx = RUN;
      RUN:     if (abort) state_nx = IDLE; else if (last_px) state_nx = DRAIN;
      DRAIN:   if (abort || done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hin_q    <= '0;
      hout_q   <= '0;
      cin_q    <= '0;
      stride_q <= '0;
      rnd_q    <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= begin_job && !cfg_legal;
      if (begin_job) begin
        hin_q    <= cfg_hin;
        hout_q   <= cfg_hout;
        cin_q    <= cfg_cin;
        stride_q <= cfg_stride;
        rnd_q    <= cfg_round;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || 1'b0) begin
      row     <= '0;
      col     <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      row_acc <= '0;
      col_acc <= '0;
      chan    <= '0;
    end else if (kill) begin
      row     <= '0;
      col     <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      row_acc <= '0;
      col_acc <= '0;
      chan    <= '0;
    end else if (begin_job) begin
      row     <= '0;
      col     <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      row_acc <= off_new;
      col_acc <= off_new;
      chan    <= '0;
    end else if (accept) begin
      if (col_end) begin
        col     <= '0;
        col_cnt <= '0;
        col_acc <= off_q;
        if (row_end) begin
          row     <= '0;
          row_cnt <= '0;
          row_acc <= off_q;
          chan    <= chan + CW'(1);
        end else begin
          row <= row + HW'(1);
          if (row_hit) begin
            row_acc <= row_acc + AW'(stride_q);
            row_cnt <= row_cnt + HW'(1);
          end
        end
      end else begin
        col <= col + HW'(1);
        if (push) begin
          col_acc <= col_acc + AW'(stride_q);
          col_cnt <= col_cnt + HW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem_d[i] <= '0;
        mem_l[i] <= 1'b0;
        mem_c[i] <= '0;
      end
    end else if (kill) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr] <= in_data;
        mem_l[wr_ptr] <= push_last;
        mem_c[wr_ptr] <= chan;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_flex_downsample_stream.sv
module tb_flex_downsample_stream;

  localparam int DW   = 8;
  localparam int HMAX = 64;
  localparam int CMAX = 256;
  localparam int HW   = 7;
  localparam int CW   = 9;

  logic          clk, rst, start, abort;
  logic [HW-1:0] cfg_hin, cfg_hout;
  logic [CW-1:0] cfg_cin;
  logic [15:0]   cfg_stride;
  logic          cfg_round;
  logic          busy, done, cfg_err;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_chan;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic [CW-1:0] ch;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            out_cnt = 0;
  int            done_cnt = 0;
  int            chan_idx = 0;
  int            drv_n = 0;
  int            cap_ch[2];
  int            cap_idx[2];
  logic [DW-1:0] cap_val[2];

  flex_downsample_stream #(.DW(DW), .HMAX(HMAX), .CMAX(CMAX)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_hin(cfg_hin), .cfg_hout(cfg_hout), .cfg_cin(cfg_cin),
    .cfg_stride(cfg_stride), .cfg_round(cfg_round),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_chan(out_chan)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int samp(input int k, input int stride, input int rnd);
    return (k * stride + (rnd != 0 ? 128 : 0)) >> 8;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!busy) chan_idx = 0;
      if (!rst && out_valid && out_ready) begin
        out_cnt++;
        for (int i = 0; i < 2; i++)
          if (cap_ch[i] == int'(out_chan) && cap_idx[i] == chan_idx) cap_val[i] = out_data;
        chan_idx = out_last ? 0 : chan_idx + 1;
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_last", out_last, e.l);
          chk("out_chan", out_chan, e.ch);
        end
      end
      if (done) done_cnt++;
    end
  endtask

  task automatic do_start(input int hin, hout, cin, stride, rnd);
    cfg_hin    = HW'(hin);
    cfg_hout   = HW'(hout);
    cfg_cin    = CW'(cin);
    cfg_stride = 16'(stride);
    cfg_round  = rnd[0];
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    cfg_hin    = '0;
    cfg_hout   = '0;
    cfg_cin    = '0;
    cfg_stride = 16'hFFFF;
    cfg_round  = ~cfg_round;
  endtask

  task automatic feed(input int hin, hout, cin, stride, rnd, input int max_px);
    bit   hit [HMAX];
    int   li, n, w;
    exp_t e;
    for (int i = 0; i < HMAX; i++) hit[i] = 1'b0;
    for (int k = 0; k < hout; k++)
      if (samp(k, stride, rnd) < hin) hit[samp(k, stride, rnd)] = 1'b1;
    li    = samp(hout - 1, stride, rnd);
    n     = 0;
    drv_n = 0;
    for (int ch = 0; ch < cin; ch++)
      for (int r = 0; r < hin; r++)
        for (int c = 0; c < hin; c++) begin
          if (max_px >= 0 && n >= max_px) begin
            in_valid = 1'b0;
            return;
          end
          in_valid = 1'b1;
          in_data  = DW'((10 * (r + c) + ch) % 256);
          w = 0;
          forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            w++;
            if (w > 200) begin
              chk("in_ready_wait", in_ready, 1);
              in_valid = 1'b0;
              return;
            end
          end
          if (hit[r] && hit[c]) begin
            e.d  = in_data;
            e.l  = (r == li) && (c == li);
            e.ch = CW'(ch);
            exp_q.push_back(e);
          end
          @(posedge clk); #1;
          n++;
          drv_n = n;
        end
    in_valid = 1'b0;
  endtask

  task automatic end_job(input int d0, input int o0, input int nout);
    int w = 0;
    while (done_cnt == d0 && w < 3000) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_cnt - d0, 1);
    chk("out_count", out_cnt - o0, nout);
    chk("sb_drained", exp_q.size(), 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic set_caps(input int c0, i0, c1, i1);
    cap_ch[0] = c0; cap_idx[0] = i0; cap_val[0] = 'x;
    cap_ch[1] = c1; cap_idx[1] = i1; cap_val[1] = 'x;
  endtask

  initial begin
    int d0, o0;
    int bad [4][5];
    bad = '{'{27, 19, 64, 384, 0}, '{0, 1, 1, 256, 0}, '{27, 19, 64, 255, 0}, '{27, 19, 0, 369, 0}};
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_hin = '0; cfg_hout = '0; cfg_cin = '0; cfg_stride = '0; cfg_round = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    set_caps(-1, 0, -1, 0);
    fork monitor(); join_none

    // reset state
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bits", {out_last, out_chan, out_data}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // illegal configurations
    for (int i = 0; i < 4; i++) begin
      do_start(bad[i][0], bad[i][1], bad[i][2], bad[i][3], bad[i][4]);
      chk("cfg_err_pulse", cfg_err, 1);
      chk("cfg_err_busy", busy, 0);
      chk("cfg_err_in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("cfg_err_clear", cfg_err, 0);
    end

    // full job, floor
    d0 = done_cnt; o0 = out_cnt;
    set_caps(0, 1, 0, 360);
    do_start(27, 19, 64, 369, 0);
    chk("run_busy", busy, 1);
    feed(27, 19, 64, 369, 0, -1);
    end_job(d0, o0, 23104);
    chk("floor_ch0_0_1", cap_val[0], 10);
    chk("floor_ch0_18_18", cap_val[1], 244);

    // round-half-up, four channels
    d0 = done_cnt; o0 = out_cnt;
    set_caps(0, 360, 3, 19);
    do_start(27, 19, 4, 369, 1);
    feed(27, 19, 4, 369, 1, -1);
    end_job(d0, o0, 1444);
    chk("round_ch0_18_18", cap_val[0], 8);
    chk("round_ch3_1_0", cap_val[1], 13);
    set_caps(-1, 0, -1, 0);

    // output stall mid-channel
    d0 = done_cnt; o0 = out_cnt; drv_n = 0;
    do_start(27, 19, 1, 369, 0);
    fork
      feed(27, 19, 1, 369, 0, -1);
      begin
        int w = 0;
        while (drv_n < 27 && w < 2000) begin
          @(posedge clk); #1;
          w++;
        end
        out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        if (exp_q.size() != 0) chk("stall_hold", out_data, exp_q[0].d);
        out_ready = 1'b1;
      end
    join
    end_job(d0, o0, 361);

    // abort during channel 5
    d0 = done_cnt;
    do_start(27, 19, 8, 369, 0);
    feed(27, 19, 8, 369, 0, 5 * 729 + 100);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, d0);
    chk("abort_quiet", out_valid, 0);
    o0 = out_cnt;
    do_start(27, 19, 2, 369, 1);
    feed(27, 19, 2, 369, 1, -1);
    end_job(d0, o0, 722);

    // reset while draining
    d0 = done_cnt;
    do_start(4, 4, 1, 256, 0);
    feed(4, 4, 1, 256, 0, -1);
    out_ready = 1'b0;
    chk("drain_busy", busy, 1);
    chk("drain_in_ready", in_ready, 0);
    chk("drain_out_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cfg_err", cfg_err, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_bits", {out_last, out_chan, out_data}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_no_done", done_cnt, d0);
    o0 = out_cnt;
    set_caps(0, 1, 0, 3);
    do_start(4, 2, 1, 512, 0);
    feed(4, 2, 1, 512, 0, -1);
    end_job(d0, o0, 4);
    chk("fresh_src_0_2", cap_val[0], 20);
    chk("fresh_src_2_2", cap_val[1], 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flex_downsample_stream.md
FLEX_DOWNSAMPLE_STREAM -- requirements
Module: flex_downsample_stream

Interface
REQ-001 SHALL have parameter DW, default 8, meaning pixel data width.
REQ-002 SHALL have parameter HMAX, default 64, meaning maximum input height/width; HW=$clog2(HMAX+1).
REQ-003 SHALL have parameter CMAX, default 256, meaning maximum channel count; CW=$clog2(CMAX+1).
REQ-004 SHALL have ports: clk in 1 (sole clock); rst in 1, asynchronous, active-high.
REQ-005 SHALL have ports: start in 1 (begin job); abort in 1 (synchronous cancel); cfg_hin in HW; cfg_hout in HW; cfg_cin in CW; cfg_stride in 16 (Q8.8 stride); cfg_round in 1 (0 floor, 1 round-half-up).
REQ-006 SHALL have ports: busy out 1; done out 1 (one-cycle pulse); cfg_err out 1 (one-cycle pulse).
REQ-007 SHALL have ports: in_valid in 1; in_ready out 1; in_data in DW (channel-major, then row-major input stream).
REQ-008 SHALL have ports: out_valid out 1; out_ready in 1; out_data out DW; out_last out 1 (final pixel of a channel); out_chan out CW (channel of out_data).

Function
REQ-009 SHALL implement states IDLE, RUN, DRAIN; transfers occur only when valid and ready are both high in the same cycle.
REQ-010 SHALL, in IDLE on start=1, latch all cfg_* and enter RUN next cycle if legal, else pulse cfg_err and stay IDLE.
REQ-011 SHALL treat cfg as illegal if: hin=0, hout=0, cin=0, hin>HMAX, cin>CMAX, stride<256, or ((hout-1)*stride + (round?128:0))>>8 > hin-1.
REQ-012 SHALL ignore start outside IDLE; busy=1 in RUN and DRAIN only.
REQ-013 SHALL define output sample index k (0..hout-1) as (k*stride + (round?128:0))>>8, separately for rows and columns, computed incrementally by Q8.8 accumulators with no multiplier in the data path.
REQ-014 SHALL hold input row/col counters; an accepted input pixel at (r,c) SHALL be pushed to the output buffer iff r equals the current sample row and c equals the current sample column, otherwise discarded.
REQ-015 SHALL advance the column accumulator on each push; at c=hin-1 reset column state and, if the row was sampled, advance the row accumulator.
REQ-016 SHALL, after pixel (hin-1,hin-1), reset row/col state and accumulators and increment the channel counter; out_last=1 on that channel's pixel (hout-1,hout-1).
REQ-017 SHALL buffer outputs in a 2-entry FIFO; in_ready=1 iff state=RUN, FIFO not full, and abort=0.
REQ-018 SHALL present a pushed pixel on out_valid the cycle after input acceptance (1-cycle latency), in sample order.
REQ-019 SHALL allow simultaneous push and pop when the FIFO is full, without loss or duplication.
REQ-020 SHALL hold out_data/out_last/out_chan stable while out_valid=1 and out_ready=0.
REQ-021 SHALL enter DRAIN after the last input pixel of channel cin-1 with in_ready=0, pulse done in the cycle the last output is popped, and return to IDLE.
REQ-022 SHALL, on abort=1 in RUN or DRAIN, flush the FIFO, clear counters, drop out_valid next cycle, return to IDLE, and not pulse done.
REQ-023 SHALL keep all accumulators HW+8+1 bits wide so no wrap-around occurs for any legal configuration.

Reset
REQ-024 SHALL, while rst=1, force IDLE and drive busy, done, cfg_err, in_ready, out_valid, out_last, out_data, and out_chan to 0, and empty the FIFO.
REQ-025 SHALL, on rst asserted mid-job, discard all state; after release, the block accepts a new start with no residual output.

Verification
REQ-026 SHALL pass: hin=27, hout=19, cin=64, stride=369, round=0, in_data=(10*(r+c)+ch)%256 -> 361 outputs per channel; ch0 (0,1)=10, ch0 (18,18)=244 (src 25,25); done once after 23104 outputs.
REQ-027 SHALL pass: same as REQ-026 with round=1 -> ch0 (18,18)=8 (src 26,26); ch3 (1,0)=13.
REQ-028 SHALL pass: hin=27, hout=19, stride=384 -> cfg_err pulse, busy stays 0, in_ready stays 0.
REQ-029 SHALL pass: out_ready low 10 cycles mid-channel -> in_ready drops once FIFO holds 2; output sequence identical to unstalled run.
REQ-030 SHALL pass: abort during channel 5 -> out_valid=0 next cycle, no done pulse; subsequent start runs a full job correctly.
REQ-031 SHALL pass: rst pulse during DRAIN -> all outputs 0 next cycle; a fresh hin=4, hout=2, cin=1, stride=512 job outputs src pixels (0,0),(0,2),(2,0),(2,2).
